// File: rtl/bp_cfg_param_streamer_pkg.sv
// Shared types, the processor configuration table and helpers for the config streamer.
package bp_cfg_param_streamer_pkg;

  localparam int unsigned max_cfgs_gp       = 128;
  localparam int unsigned lg_max_cfgs_gp    = $clog2(max_cfgs_gp);
  localparam int unsigned num_table_cfgs_gp = 10;

  // Processor parameter set; first field lands in the MSBs of the flattened image.
  typedef struct packed {
    logic [7:0]  cc_x_dim;
    logic [7:0]  cc_y_dim;
    logic [7:0]  ic_y_dim;
    logic [7:0]  mc_y_dim;
    logic [7:0]  cac_x_dim;
    logic [7:0]  sac_x_dim;
    logic [7:0]  vaddr_width;
    logic [7:0]  paddr_width;
    logic [7:0]  daddr_width;
    logic [7:0]  caddr_width;
    logic [7:0]  branch_metadata_fwd_width;
    logic [7:0]  btb_tag_width;
    logic [7:0]  bht_idx_width;
    logic [7:0]  ghist_width;
    logic [15:0] icache_sets;
    logic [7:0]  icache_assoc;
    logic [15:0] icache_block_width;
    logic [15:0] dcache_sets;
    logic [7:0]  dcache_assoc;
    logic [15:0] dcache_block_width;
    logic [7:0]  l2_en;
  } bp_proc_param_s;

  typedef struct packed {
    logic        err;
    logic [15:0] words;
    logic [7:0]  cfg_id;
  } bp_cfg_stream_hdr_s;

  typedef enum logic [1:0] {StIdle, StHdr, StData} bp_cfg_stream_state_e;

  // Number of data_width-bit beats needed to carry cfg_width bits.
  function automatic int unsigned cfg_beats(int unsigned cfg_width, int unsigned data_width);
    return (cfg_width + data_width - 1) / data_width;
  endfunction

  // Builds one table entry; entry 0 is the invalid config and stays all-zero.
  function automatic bp_proc_param_s mk_cfg(int unsigned id, int unsigned x, int unsigned y);
    bp_proc_param_s c;
    c = '0;
    if (id != 0) begin
      c.cc_x_dim                  = 8'(x);
      c.cc_y_dim                  = 8'(y);
      c.ic_y_dim                  = 8'd1;
      c.mc_y_dim                  = 8'(y / 2);
      c.cac_x_dim                 = 8'(x / 2);
      c.sac_x_dim                 = 8'(id % 3);
      c.vaddr_width               = 8'd39;
      c.paddr_width               = 8'(40 + id);
      c.daddr_width               = 8'd32;
      c.caddr_width               = 8'd31;
      c.branch_metadata_fwd_width = 8'(30 + id);
      c.btb_tag_width             = 8'(10 + id);
      c.bht_idx_width             = 8'(7 + id);
      c.ghist_width               = 8'd2;
      c.icache_sets               = 16'(64 << (id % 3));
      c.icache_assoc              = 8'(1 << (id % 4));
      c.icache_block_width        = 16'd512;
      c.dcache_sets               = 16'(64 << (id % 2));
      c.dcache_assoc              = 8'd8;
      c.dcache_block_width        = 16'd512;
      c.l2_en                     = 8'(id % 2);
    end
    return c;
  endfunction

  localparam bp_proc_param_s all_cfgs_gp [num_table_cfgs_gp] = '{
    mk_cfg(0, 0, 0), mk_cfg(1, 1, 1), mk_cfg(2, 2, 1), mk_cfg(3, 1, 2), mk_cfg(4, 4, 1),
    mk_cfg(5, 2, 2), mk_cfg(6, 4, 2), mk_cfg(7, 2, 4), mk_cfg(8, 4, 4), mk_cfg(9, 8, 8)
  };

  // Mux-style lookup so an out-of-table index yields zeros rather than X.
  function automatic bp_proc_param_s cfg_lookup(logic [lg_max_cfgs_gp-1:0] idx);
    bp_proc_param_s r;
    r = '0;
    for (int i = 0; i < num_table_cfgs_gp; i++) begin
      if (idx == lg_max_cfgs_gp'(i)) r = all_cfgs_gp[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_cfg_param_streamer_if.sv
// Request and beat-stream signals between a host and the config streamer.
interface bp_cfg_param_streamer_if #(
  parameter int unsigned data_width_p = 64
);
  import bp_cfg_param_streamer_pkg::*;

  logic [lg_max_cfgs_gp-1:0] req_cfg;
  logic                      req_v;
  logic                      req_ready;
  logic [data_width_p-1:0]   data;
  logic                      v;
  logic                      last;
  logic                      yumi;

  modport master (
    output req_cfg, req_v, yumi,
    input  req_ready, data, v, last
  );

  modport slave (
    input  req_cfg, req_v, yumi,
    output req_ready, data, v, last
  );

endinterface

// File: rtl/bp_cfg_param_streamer_cnt.sv
// Beat counter with synchronous clear and increment.
module bp_cfg_param_streamer_cnt #(
  parameter int unsigned width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_d, count_q;

  // Clear takes effect before the increment in the same cycle.
  always_comb begin
    count_d = (clear_i ? '0 : count_q) + width_p'(up_i);
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_cfg_param_streamer.sv
// Streams one entry of the processor config table as a header beat plus data beats.
module bp_cfg_param_streamer
  import bp_cfg_param_streamer_pkg::*;
#(
  parameter int unsigned data_width_p = 64,
  parameter int unsigned num_cfgs_p   = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bp_cfg_param_streamer_if.slave bus_io
);

  localparam int unsigned cfg_width_lp  = $bits(bp_proc_param_s);
  localparam int unsigned words_lp      = cfg_beats(cfg_width_lp, data_width_p);
  localparam int unsigned cnt_width_lp  = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int unsigned flat_width_lp = words_lp * data_width_p;

  bp_cfg_stream_state_e state_d, state_q;
  logic [lg_max_cfgs_gp-1:0] idx_d, idx_q;
  logic err_d, err_q;
  logic [words_lp-1:0][data_width_p-1:0] flat_d, flat_q;

  logic [cnt_width_lp-1:0] cnt;
  logic cnt_clear, cnt_up;
  logic req_err;
  logic req_ready, v, last;
  logic [data_width_p-1:0] data;
  bp_cfg_stream_hdr_s hdr;

  bp_cfg_param_streamer_cnt #(
    .width_p (cnt_width_lp)
  ) u_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear),
    .up_i    (cnt_up),
    .count_o (cnt)
  );

  // Index 0 is the invalid config; anything past the populated range is also an error.
  assign req_err = (bus_io.req_cfg == '0) || (32'(bus_io.req_cfg) >= num_cfgs_p);

  // Header beat contents.
  always_comb begin
    hdr        = '0;
    hdr.err    = err_q;
    hdr.words  = 16'(words_lp);
    hdr.cfg_id = 8'(idx_q);
  end

  // Next-state, register loads and beat outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    flat_d    = flat_q;
    cnt_clear = 1'b0;
    cnt_up    = 1'b0;
    req_ready = 1'b0;
    v         = 1'b0;
    last      = 1'b0;
    data      = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus_io.req_v) begin
          idx_d   = bus_io.req_cfg;
          err_d   = req_err;
          // Pad bits above the entry width are zero, so the final beat needs no masking.
          flat_d  = req_err ? '0 : flat_width_lp'(cfg_lookup(bus_io.req_cfg));
          state_d = StHdr;
        end
      end
      StHdr: begin
        v    = 1'b1;
        data = data_width_p'(hdr);
        last = err_q;
        if (bus_io.yumi) begin
          if (err_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            cnt_clear = 1'b1;
          end
        end
      end
      StData: begin
        v    = 1'b1;
        data = flat_q[cnt];
        last = (cnt == cnt_width_lp'(words_lp - 1));
        if (bus_io.yumi) begin
          cnt_up = 1'b1;
          if (last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= 1'b0;
      flat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      flat_q  <= flat_d;
    end
  end

  assign bus_io.req_ready = req_ready;
  assign bus_io.v         = v;
  assign bus_io.last      = last;
  assign bus_io.data      = data;

`ifndef SYNTHESIS
  // Catch a consumer taking a beat that is not offered, and an unsupported beat width.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(bus_io.yumi && !v)) else $error("yumi_i asserted while v_o is low");
    end
    assert (data_width_p >= 32) else $error("data_width_p must be at least 32");
  end
`endif

endmodule

// File: tb/tb_bp_cfg_param_streamer.sv
// Scoreboard bench for the config streamer with a table-driven reference model.
module tb_bp_cfg_param_streamer;
  import bp_cfg_param_streamer_pkg::*;

  localparam int unsigned Dw      = 64;
  localparam int unsigned NumCfgs = 10;
  localparam int unsigned CfgW    = $bits(bp_proc_param_s);
  localparam int unsigned Words   = (CfgW + Dw - 1) / Dw;

  typedef struct {
    logic [Dw-1:0] data;
    bit            last;
    bit            hdr;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  bp_cfg_param_streamer_if #(.data_width_p(Dw)) bus ();

  bp_cfg_param_streamer #(
    .data_width_p (Dw),
    .num_cfgs_p   (NumCfgs)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  beat_t         sb[$];
  logic [Dw-1:0] rx_q[$];
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  int unsigned   cyc      = 0;
  int unsigned   last_pop_cyc = 0;
  int unsigned   pop_cnt  = 0;
  int unsigned   yumi_mode = 0;
  bit            yumi_hold = 0;
  int unsigned   ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [Dw-1:0] act, input logic [Dw-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected event, expected normal completion", nm);
  endtask

  // Reference model: header word from plain arithmetic, data from the table image.
  function automatic void push_expected(input logic [lg_max_cfgs_gp-1:0] idx);
    bit err;
    logic [Dw-1:0] h;
    logic [Words*Dw-1:0] img;
    beat_t b;
    err = (idx == 0) || (int'(idx) >= NumCfgs);
    h = Dw'(idx) | (Dw'(Words) << 8) | (Dw'(err) << 24);
    b.data = h; b.last = err; b.hdr = 1'b1;
    sb.push_back(b);
    if (!err) begin
      img = '0;
      img[CfgW-1:0] = all_cfgs_gp[int'(idx)];
      for (int w = 0; w < Words; w++) begin
        b.data = img[w*Dw +: Dw];
        b.last = (w == Words - 1);
        b.hdr  = 1'b0;
        sb.push_back(b);
      end
    end
  endfunction

  // Consumer: takes beats according to the selected pattern.
  initial begin
    bus.yumi = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset || yumi_hold) bus.yumi = 1'b0;
      else begin
        case (yumi_mode)
          0: bus.yumi = bus.v;
          1: begin
            bus.yumi = bus.v && (ph == 0);
            if (bus.v) ph = (ph + 1) % 4;
          end
          default: bus.yumi = bus.v && ($urandom_range(0, 1) == 1);
        endcase
      end
    end
  end

  // Monitor: every offered beat must match the scoreboard head; pop on yumi.
  always @(negedge clk) begin
    if (!reset && bus.v) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        chk("beat_data", bus.data, sb[0].data);
        chk("beat_last", Dw'(bus.last), Dw'(sb[0].last));
        if (bus.yumi) begin
          if (!sb[0].hdr) rx_q.push_back(bus.data);
          if (sb[0].last) last_pop_cyc = cyc;
          pop_cnt++;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic do_req(input logic [lg_max_cfgs_gp-1:0] idx, input bit keep_v);
    bit got;
    got = 0;
    @(posedge clk); #2;
    bus.req_cfg = idx;
    bus.req_v   = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1;
        push_expected(idx);
      end
    end
    if (!got) fail_now("req_accept");
    if (!keep_v) begin
      @(posedge clk); #2;
      bus.req_v = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && bus.req_ready) done = 1;
    end
    if (!done) fail_now("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int unsigned acc2;
    logic [Words*Dw-1:0] img;
    bp_proc_param_s dec;
    logic [lg_max_cfgs_gp-1:0] ridx;

    reset = 1'b1;
    bus.req_v = 1'b0;
    bus.req_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", Dw'(bus.req_ready), 1);
    chk("rst_v", Dw'(bus.v), 0);
    chk("rst_last", Dw'(bus.last), 0);
    chk("rst_data", bus.data, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Valid config, continuous consumer.
    yumi_mode = 0;
    do_req(7'd2, 0);
    wait_idle();

    // Invalid config 0: one error header, ready again the following cycle.
    do_req(7'd0, 0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) got = 1;
    end
    if (!got) fail_now("err_hdr_pop");
    @(negedge clk); #1;
    chk("err_ready_back", Dw'(bus.req_ready), 1);
    chk("err_ready_cycle", Dw'(cyc - last_pop_cyc), 1);

    // Out-of-range index.
    do_req(7'd127, 0);
    wait_idle();

    // Backpressure 1 on / 3 off, then decode the reassembled entry.
    yumi_mode = 1;
    ph = 0;
    rx_q.delete();
    do_req(7'd5, 0);
    wait_idle();
    chk("cfg5_beats", Dw'(rx_q.size()), Dw'(Words));
    img = '0;
    for (int i = 0; i < rx_q.size() && i < Words; i++) img[i*Dw +: Dw] = rx_q[i];
    dec = bp_proc_param_s'(img[CfgW-1:0]);
    chk("cfg5_cc_x_dim", Dw'(dec.cc_x_dim), 2);
    chk("cfg5_cc_y_dim", Dw'(dec.cc_y_dim), 2);

    // Reset during data beat 2 of cfg 9, then a clean cfg 3 stream.
    yumi_mode = 0;
    pop_cnt = 0;
    do_req(7'd9, 0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #2;
      if (pop_cnt == 3) got = 1;
    end
    if (!got) fail_now("reach_beat2");
    yumi_hold = 1;
    bus.yumi = 1'b0;
    reset = 1'b1;
    @(posedge clk); #2;
    chk("mid_reset_v", Dw'(bus.v), 0);
    chk("mid_reset_ready", Dw'(bus.req_ready), 1);
    sb.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    yumi_hold = 0;
    do_req(7'd3, 0);
    wait_idle();

    // Requester holds req_v across a response; next accept one cycle after last yumi.
    do_req(7'd2, 1);
    @(posedge clk); #2;
    bus.req_cfg = 7'd7;
    got = 0;
    acc2 = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1;
        acc2 = cyc;
        push_expected(7'd7);
      end
    end
    if (!got) fail_now("b2b_accept");
    else chk("b2b_gap", Dw'(acc2 - last_pop_cyc), 1);
    @(posedge clk); #2;
    bus.req_v = 1'b0;
    wait_idle();

    // Randomised requests and consumer stalls.
    yumi_mode = 2;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) ridx = 7'($urandom);
      else ridx = 7'($urandom_range(1, NumCfgs - 1));
      do_req(ridx, 0);
      wait_idle();
    end

    chk("sb_empty", Dw'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
